codec_stream_arbiter: RTL and testbench
=======================================

CODEC_STREAM_ARBITER -- requirements
Module: codec_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the width of each audio sample per channel.
REQ-002 SHALL have parameter MUTE_SAMPLES, default 16, meaning the number of zero stereo samples written on a source switch (1..255).
REQ-003 SHALL have port CLOCK_50  in  1  system clock; all logic is on its posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port sel  in  1  requested source; 0 = mic loopback (src0), 1 = ROM tone (src1); driven by SW[9].
REQ-006 SHALL have ports src0_valid/src1_valid  in  1  source holds a stereo sample.
REQ-007 SHALL have ports src0_left/src0_right/src1_left/src1_right  in  DATA_W  source samples.
REQ-008 SHALL have ports src0_ack/src1_ack  out  1  one-cycle pulse; the sample was consumed.
REQ-009 SHALL have ports read_ready, write_ready  in  1, and read, write  out  1: the codec handshake.
REQ-010 SHALL have ports readdata_left/readdata_right  in  DATA_W, and writedata_left/writedata_right  out  DATA_W: codec data.
REQ-011 SHALL have ports adc_valid  out  1, and adc_left/adc_right  out  DATA_W: captured ADC sample forwarded to the mic source.
REQ-012 SHALL have ports active_src  out  1 (source currently owning the DAC) and muting  out  1 (high in MUTE).

Function
REQ-013 The FSM SHALL have states IDLE, WRITE and MUTE.
REQ-014 IDLE with sel==active_src and the active source's valid=1: pulse that source's ack this cycle, latch its left/right into writedata at the edge, then go to WRITE.
REQ-015 In WRITE, write=1 exactly in cycles where write_ready=1; the next state is IDLE; write is never high outside WRITE/MUTE.
REQ-016 Sample latency: ack at cycle N; earliest write at N+1.
REQ-017 IDLE with sel!=active_src: update active_src to sel, no ack; with the macro, go to MUTE; without it, stay in IDLE.
REQ-018 A sel change during WRITE or MUTE SHALL NOT abort that state; the old sample completes first, and the switch is evaluated on the next IDLE.
REQ-019 MUTE: writedata=0; one write per write_ready cycle; a counter counts writes; after MUTE_SAMPLES writes go to IDLE.
REQ-020 If sel differs from active_src when MUTE ends, the IDLE rule applies again, giving a further switch and mute.
REQ-021 The inactive source's ack SHALL stay 0; ack and write SHALL never be high for both sources.
REQ-022 read SHALL equal read_ready in every state and for either source, always draining the ADC to prevent overflow.
REQ-023 adc_valid SHALL pulse one cycle after read, with adc_left/adc_right registered from readdata, only when active_src==0; otherwise the data is discarded.
REQ-024 Sample data SHALL pass unmodified; no arithmetic except the mute counter, which is $clog2(MUTE_SAMPLES+1) wide and saturates at terminal count.

Reset
REQ-025 On reset: state=IDLE; active_src=0; all outputs 0, including writedata, adc_* and the counter.
REQ-026 Reset mid-WRITE or mid-MUTE SHALL drop the pending sample with no write; after release, active_src is taken from sel via the normal IDLE switch rule.

Configuration
REQ-027 Macro CODEC_ARB_MUTE_EN SHALL control mute insertion.
REQ-028 With CODEC_ARB_MUTE_EN defined: the MUTE state, counter and muting output exist as described.
REQ-029 Without CODEC_ARB_MUTE_EN: no MUTE state; the switch is immediate in IDLE; muting is tied 0; MUTE_SAMPLES is ignored.

Structure
REQ-030 Shared package audio_pkg SHALL hold the state enum (IDLE/WRITE/MUTE), the SRC_MIC=0 / SRC_TONE=1 constants and the default DATA_W=24.
REQ-031 One sub-module, audio_mute_counter, holding the MUTE_SAMPLES write counter with a done flag.
REQ-032 The top level SHALL replace the ad-hoc SW[9] mux with this block.

Verification
REQ-033 Reset with sel=0, then src0_valid=1, src0_left=24'h123456, write_ready=1 -> src0_ack at cycle N, write at N+1, writedata_left=24'h123456.
REQ-034 write_ready held 0 for 20 cycles in WRITE -> write stays 0, writedata stable, no further ack; write fires on the first write_ready=1.
REQ-035 Macro defined, sel 0->1 during WRITE -> current src0 sample is written, then 16 zero writes with muting=1, then first src1 sample; src0_ack stays 0 throughout.
REQ-036 sel toggles 1->0 during MUTE -> MUTE completes 16 writes, then a second 16-write MUTE, active_src=0.
REQ-037 read_ready pulses with sel=1 -> read pulses and adc_valid stays 0; with sel=0, adc_valid follows read by one cycle and carries readdata.
REQ-038 Reset asserted mid-MUTE (after 5 writes) -> next cycle all outputs 0 and state IDLE; macro undefined -> switch gives 0 zero writes and muting stays 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions: arbiter state encoding, source ids and default sample width.
package audio_pkg;

  localparam int unsigned DATA_W_DEFAULT = 24;

  localparam logic SRC_MIC  = 1'b0;
  localparam logic SRC_TONE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    MUTE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/audio_mute_counter.sv
// Counts zero-sample writes during a source-switch mute; done_c flags the final write.
module audio_mute_counter #(
  parameter int unsigned MUTE_SAMPLES = 16
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic done_c
);

  localparam int unsigned CNT_W = $clog2(MUTE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(MUTE_SAMPLES);

  logic [CNT_W-1:0] count;

  // Saturating write counter, cleared on entry to a mute burst.
  always_ff @(posedge CLOCK_50) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != TERM)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done_c = inc && (count == (TERM - CNT_W'(1)));

endmodule

// File: rtl/codec_stream_arbiter.sv
// Selects mic loopback or ROM tone as the DAC stream and forwards ADC samples to the mic path.
// Optional click-suppression mute on source switch: define CODEC_ARB_MUTE_EN.
module codec_stream_arbiter
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEFAULT,
  parameter int unsigned MUTE_SAMPLES = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              sel,
  input  logic              src0_valid,
  input  logic              src1_valid,
  input  logic [DATA_W-1:0] src0_left,
  input  logic [DATA_W-1:0] src0_right,
  input  logic [DATA_W-1:0] src1_left,
  input  logic [DATA_W-1:0] src1_right,
  output logic              src0_ack,
  output logic              src1_ack,
  input  logic              read_ready,
  input  logic              write_ready,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              adc_valid,
  output logic [DATA_W-1:0] adc_left,
  output logic [DATA_W-1:0] adc_right,
  output logic              active_src,
  output logic              muting
);

  if ((MUTE_SAMPLES < 1) || (MUTE_SAMPLES > 255)) begin : g_mute_range
    $error("codec_stream_arbiter: MUTE_SAMPLES must be 1..255");
  end

  arb_state_t        state, state_nxt;
  logic              active_nxt;
  logic [DATA_W-1:0] wd_left_nxt, wd_right_nxt;
  logic              cur_valid;
  logic [DATA_W-1:0] cur_left, cur_right;
  logic              adc_capture;

  assign cur_valid   = (active_src == SRC_TONE) ? src1_valid : src0_valid;
  assign cur_left    = (active_src == SRC_TONE) ? src1_left  : src0_left;
  assign cur_right   = (active_src == SRC_TONE) ? src1_right : src0_right;
  assign read        = read_ready;
  assign adc_capture = read_ready && (active_src == SRC_MIC);

`ifdef CODEC_ARB_MUTE_EN
  logic mute_clr_c, mute_inc_c, mute_done_c;

  audio_mute_counter #(
    .MUTE_SAMPLES(MUTE_SAMPLES)
  ) u_mute_counter (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clr     (mute_clr_c),
    .inc     (mute_inc_c),
    .done_c  (mute_done_c)
  );

  assign muting = (state == MUTE);
`else
  assign muting = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshakes and next values of the DAC-side registers.
  always_comb begin
    state_nxt    = state;
    active_nxt   = active_src;
    wd_left_nxt  = writedata_left;
    wd_right_nxt = writedata_right;
    src0_ack     = 1'b0;
    src1_ack     = 1'b0;
    write        = 1'b0;
`ifdef CODEC_ARB_MUTE_EN
    mute_clr_c   = 1'b0;
    mute_inc_c   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sel != active_src) begin
          active_nxt = sel;
`ifdef CODEC_ARB_MUTE_EN
          state_nxt    = MUTE;
          mute_clr_c   = 1'b1;
          wd_left_nxt  = '0;
          wd_right_nxt = '0;
`endif
        end else if (cur_valid) begin
          src0_ack     = (active_src == SRC_MIC);
          src1_ack     = (active_src == SRC_TONE);
          wd_left_nxt  = cur_left;
          wd_right_nxt = cur_right;
          state_nxt    = WRITE;
        end
      end
      WRITE: begin
        write = write_ready;
        if (write_ready) begin
          state_nxt = IDLE;
        end
      end
`ifdef CODEC_ARB_MUTE_EN
      MUTE: begin
        write      = write_ready;
        mute_inc_c = write_ready;
        if (mute_done_c) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // A reset cycle drops any pending sample without handshaking.
    if (reset) begin
      src0_ack = 1'b0;
      src1_ack = 1'b0;
      write    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      active_src      <= SRC_MIC;
      writedata_left  <= '0;
      writedata_right <= '0;
      adc_valid       <= 1'b0;
      adc_left        <= '0;
      adc_right       <= '0;
    end else begin
      active_src      <= active_nxt;
      writedata_left  <= wd_left_nxt;
      writedata_right <= wd_right_nxt;
      adc_valid       <= adc_capture;
      if (adc_capture) begin
        adc_left  <= readdata_left;
        adc_right <= readdata_right;
      end
    end
  end

endmodule

// File: tb/tb_codec_stream_arbiter.sv
// Bench for codec_stream_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_codec_stream_arbiter;

  localparam int unsigned DW = 24;
  localparam int unsigned MS = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sel = 1'b0;
  logic          src0_valid = 1'b0, src1_valid = 1'b0;
  logic [DW-1:0] src0_left = '0, src0_right = '0, src1_left = '0, src1_right = '0;
  logic          read_ready = 1'b0, write_ready = 1'b0;
  logic [DW-1:0] readdata_left = '0, readdata_right = '0;
  logic          src0_ack, src1_ack, read, write, adc_valid, active_src, muting;
  logic [DW-1:0] writedata_left, writedata_right, adc_left, adc_right;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  always #10 clk = ~clk;

  codec_stream_arbiter #(.DATA_W(DW), .MUTE_SAMPLES(MS)) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .sel            (sel),
    .src0_valid     (src0_valid),
    .src1_valid     (src1_valid),
    .src0_left      (src0_left),
    .src0_right     (src0_right),
    .src1_left      (src1_left),
    .src1_right     (src1_right),
    .src0_ack       (src0_ack),
    .src1_ack       (src1_ack),
    .read_ready     (read_ready),
    .write_ready    (write_ready),
    .read           (read),
    .write          (write),
    .readdata_left  (readdata_left),
    .readdata_right (readdata_right),
    .writedata_left (writedata_left),
    .writedata_right(writedata_right),
    .adc_valid      (adc_valid),
    .adc_left       (adc_left),
    .adc_right      (adc_right),
    .active_src     (active_src),
    .muting         (muting)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a queue of DAC writes still owed; empty queue means the arbiter is free.
  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          mute;
  } ent_t;

  ent_t          q[$];
  logic          m_active = 1'b0;
  logic [DW-1:0] m_wl = '0, m_wr = '0, m_al = '0, m_ar = '0;
  logic          m_adc_v = 1'b0;
  logic          e_ack0, e_ack1, e_write, e_muting;

  always @(negedge clk) begin
    e_ack0   = 1'b0;
    e_ack1   = 1'b0;
    e_write  = 1'b0;
    e_muting = (q.size() != 0) && q[0].mute;
    if (!reset) begin
      if (q.size() == 0) begin
        if (sel == m_active && (m_active ? src1_valid : src0_valid)) begin
          e_ack0 = !m_active;
          e_ack1 = m_active;
        end
      end else begin
        e_write = write_ready;
      end
    end
    if (chk_en) begin
      chk("src0_ack", 64'(src0_ack), 64'(e_ack0));
      chk("src1_ack", 64'(src1_ack), 64'(e_ack1));
      chk("write", 64'(write), 64'(e_write));
      chk("read", 64'(read), 64'(read_ready));
      chk("writedata_left", 64'(writedata_left), 64'(m_wl));
      chk("writedata_right", 64'(writedata_right), 64'(m_wr));
      chk("active_src", 64'(active_src), 64'(m_active));
      chk("muting", 64'(muting), 64'(e_muting));
      chk("adc_valid", 64'(adc_valid), 64'(m_adc_v));
      chk("adc_left", 64'(adc_left), 64'(m_al));
      chk("adc_right", 64'(adc_right), 64'(m_ar));
    end
    // Advance the model to the state after the coming clock edge.
    if (reset) begin
      q.delete();
      m_active = 1'b0;
      m_wl = '0; m_wr = '0; m_al = '0; m_ar = '0;
      m_adc_v = 1'b0;
    end else begin
      m_adc_v = read_ready && !m_active;
      if (m_adc_v) begin
        m_al = readdata_left;
        m_ar = readdata_right;
      end
      if (q.size() == 0) begin
        if (sel != m_active) begin
          m_active = sel;
`ifdef CODEC_ARB_MUTE_EN
          for (int i = 0; i < int'(MS); i++) q.push_back('{l: '0, r: '0, mute: 1'b1});
          m_wl = '0;
          m_wr = '0;
`endif
        end else if (m_active ? src1_valid : src0_valid) begin
          m_wl = m_active ? src1_left  : src0_left;
          m_wr = m_active ? src1_right : src0_right;
          q.push_back('{l: m_wl, r: m_wr, mute: 1'b0});
        end
      end else if (write_ready) begin
        void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int zero_writes;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_write", 64'(write), 64'd0);
    chk("reset_writedata", 64'(writedata_left), 64'd0);
    chk("reset_active", 64'(active_src), 64'd0);
    chk("reset_adc_valid", 64'(adc_valid), 64'd0);

    // First sample: ack in cycle N, write in N+1.
    step();
    reset = 1'b0; src0_valid = 1'b1; src0_left = 24'h123456; src0_right = 24'h0abcde;
    write_ready = 1'b1;
    @(negedge clk);
    chk("first_ack", 64'(src0_ack), 64'd1);
    chk("first_no_write", 64'(write), 64'd0);
    step();
    src0_valid = 1'b0;
    @(negedge clk);
    chk("first_write", 64'(write), 64'd1);
    chk("first_wdata", 64'(writedata_left), 64'h123456);
    chk("first_no_ack", 64'(src0_ack), 64'd0);

    // Codec back-pressure for 20 cycles.
    step();
    src0_valid = 1'b1; src0_left = 24'h00beef; write_ready = 1'b0;
    @(negedge clk);
    chk("bp_ack", 64'(src0_ack), 64'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge clk);
      chk("bp_write_held", 64'(write), 64'd0);
      chk("bp_no_ack", 64'(src0_ack), 64'd0);
      chk("bp_wdata", 64'(writedata_left), 64'h00beef);
    end
    step();
    write_ready = 1'b1; src0_valid = 1'b0;
    @(negedge clk);
    chk("bp_release_write", 64'(write), 64'd1);

    // ADC forwarding with mic active.
    step();
    write_ready = 1'b0; read_ready = 1'b1;
    readdata_left = 24'h5a5a5a; readdata_right = 24'ha5a5a5;
    @(negedge clk);
    chk("mic_read", 64'(read), 64'd1);
    step();
    read_ready = 1'b0;
    @(negedge clk);
    chk("mic_adc_valid", 64'(adc_valid), 64'd1);
    chk("mic_adc_left", 64'(adc_left), 64'h5a5a5a);
    chk("mic_adc_right", 64'(adc_right), 64'ha5a5a5);

    // Switch to tone and count zero writes.
    step();
    sel = 1'b1; write_ready = 1'b1;
    zero_writes = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      @(negedge clk);
      if (write && muting && writedata_left == '0) zero_writes++;
    end
`ifdef CODEC_ARB_MUTE_EN
    chk("switch_zero_writes", 64'(zero_writes), 64'd16);
`else
    chk("switch_zero_writes", 64'(zero_writes), 64'd0);
`endif
    chk("switch_active", 64'(active_src), 64'd1);

    // ADC discarded with tone active.
    step();
    read_ready = 1'b1; readdata_left = 24'h777777;
    @(negedge clk);
    chk("tone_read", 64'(read), 64'd1);
    step();
    read_ready = 1'b0;
    @(negedge clk);
    chk("tone_adc_valid", 64'(adc_valid), 64'd0);

    // Reset part-way through a switch back to mic.
    step();
    sel = 1'b0; write_ready = 1'b1;
    repeat (6) step();
    reset = 1'b1; write_ready = 1'b0;
    step();
    @(negedge clk);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_muting", 64'(muting), 64'd0);
    chk("rst_wdata", 64'(writedata_left), 64'd0);
    chk("rst_active", 64'(active_src), 64'd0);
    step();
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step();
      reset       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) sel = ~sel;
      src0_valid  = 1'($urandom_range(0, 1));
      src1_valid  = 1'($urandom_range(0, 1));
      src0_left   = DW'($urandom); src0_right = DW'($urandom);
      src1_left   = DW'($urandom); src1_right = DW'($urandom);
      write_ready = ($urandom_range(0, 9) < 6);
      read_ready  = 1'($urandom_range(0, 1));
      readdata_left  = DW'($urandom);
      readdata_right = DW'($urandom);
    end
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
